// File: rtl/avmm_reg_master_pkg.sv
// Shared definitions for the register-mapped Avalon-MM master.
//   state_t         : sequencer states (IDLE, WR, RD, RD_CAP)
//   CTRL_*          : bit positions inside the MCU control register write
//   STAT_*          : bit positions inside the status word
package avmm_reg_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_t;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_CLR_OVF  = 1;

    localparam int STAT_OVF      = 7;
    localparam int STAT_AUTO_INC = 6;
    localparam int STAT_RD_BUSY  = 5;
    localparam int STAT_CNT_W    = 5;   // count occupies [4:0]

endpackage

// File: rtl/avmm_wq_fifo.sv
// Posted-write queue: synchronous first-word-fall-through FIFO.
//   sysclk, sysreset : clock, synchronous active-high reset (flushes the queue)
//   push, din        : write an entry; ignored when full
//   pop              : drop the head entry; ignored when empty
//   dout             : current head entry (valid while !empty)
//   count            : number of entries held
//   full, empty      : occupancy flags
module avmm_wq_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/avmm_reg_master.sv
// Register-mapped Avalon-MM master fronting the supervised MCU.
// MCU register loads become posted Avalon writes (queued), MCU reads of the
// write-data register become Avalon reads ordered behind all queued writes.
//   sysclk, sysreset          : clock, synchronous active-high reset
//   load_data                 : MCU write data for every ld_* strobe
//   ld_ad_hi / ld_ad_lo       : load address high / low word
//   ld_wdata                  : queue a write of load_data at the current address
//   ld_ctrl                   : [0] auto_inc, [1] clear overflow (command bit)
//   rd_trigger                : request an Avalon read at the current address
//   ad_hi, ad_lo              : address registers
//   rdata                     : last captured read data
//   status                    : {8'h0, overflow, auto_inc, rd_busy, count[4:0]}
//   mcu_wait                  : stall request to the MCU
//   av_*                      : Avalon-MM master port
//
// Handshake: an Avalon transfer completes on the rising edge where av_read or
// av_write is 1 and av_waitrequest is 0; address/data/command are held
// unchanged until then. The MCU side has no handshake: strobes are single
// cycle and the MCU must honour mcu_wait.
module avmm_reg_master
    import avmm_reg_master_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int WQ_DEPTH = 4,
    parameter int INC_STEP = DATA_W / 8
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [15:0]       load_data,
    input  logic              ld_ad_hi,
    input  logic              ld_ad_lo,
    input  logic              ld_wdata,
    input  logic              ld_ctrl,
    input  logic              rd_trigger,
    output logic [15:0]       ad_hi,
    output logic [15:0]       ad_lo,
    output logic [DATA_W-1:0] rdata,
    output logic [15:0]       status,
    output logic              mcu_wait,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_read,
    output logic              av_write,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_waitrequest
);

    localparam int QW = ADDR_W + DATA_W;
    localparam int CW = $clog2(WQ_DEPTH + 1);

    state_t              state;
    state_t              state_nxt;
    logic                auto_inc;
    logic                overflow;
    logic                rd_pend;
    logic [ADDR_W-1:0]   rd_addr;
    logic [31:0]         addr32;
    logic [31:0]         addr_inc;
    logic                do_inc;

    logic                wq_push;
    logic                wq_pop;
    logic [QW-1:0]       wq_din;
    logic [QW-1:0]       wq_dout;
    logic [CW-1:0]       wq_count;
    logic                wq_full;
    logic                wq_empty;

    // 32-bit add gives the hi/lo carry and the 0xFFFFFFFF -> 0 wrap for free.
    assign addr32   = {ad_hi, ad_lo};
    assign addr_inc = addr32 + 32'(INC_STEP);
    assign wq_push  = ld_wdata & ~wq_full;
    assign wq_din   = {addr32[ADDR_W-1:0], load_data[DATA_W-1:0]};
    assign do_inc   = auto_inc & (wq_push | (state == RD_CAP));

    avmm_wq_fifo #(
        .WIDTH (QW),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .push     (wq_push),
        .pop      (wq_pop),
        .din      (wq_din),
        .dout     (wq_dout),
        .count    (wq_count),
        .full     (wq_full),
        .empty    (wq_empty)
    );

    always_comb begin
        state_nxt = state;
        wq_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (!wq_empty)    state_nxt = WR;
                else if (rd_pend) state_nxt = RD;
            end
            WR: begin
                if (!av_waitrequest) begin
                    wq_pop = 1'b1;
                    // A push landing on the pop edge also keeps the burst going.
                    if ((wq_count > CW'(1)) || wq_push) state_nxt = WR;
                    else if (rd_pend)                   state_nxt = RD;
                    else                                state_nxt = IDLE;
                end
            end
            RD: begin
                if (!av_waitrequest) state_nxt = RD_CAP;
            end
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state    <= IDLE;
            ad_hi    <= '0;
            ad_lo    <= '0;
            auto_inc <= 1'b0;
            overflow <= 1'b0;
            rd_pend  <= 1'b0;
            rd_addr  <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nxt;

            if (ld_ctrl) auto_inc <= load_data[CTRL_AUTO_INC];
            // A dropped push in the same cycle as a clear still leaves overflow set.
            if (ld_wdata && wq_full)                      overflow <= 1'b1;
            else if (ld_ctrl && load_data[CTRL_CLR_OVF])  overflow <= 1'b0;

            // Any explicit address load suppresses the increment on both halves.
            if (ld_ad_hi || ld_ad_lo) begin
                if (ld_ad_hi) ad_hi <= load_data;
                if (ld_ad_lo) ad_lo <= load_data;
            end else if (do_inc) begin
                ad_hi <= addr_inc[31:16];
                ad_lo <= addr_inc[15:0];
            end

            if (state == RD_CAP)  rd_pend <= 1'b0;
            else if (rd_trigger)  rd_pend <= 1'b1;

            if ((state != RD) && (state_nxt == RD)) rd_addr <= addr32[ADDR_W-1:0];
            if ((state == RD) && !av_waitrequest)   rdata   <= av_readdata;
        end
    end

    // Avalon outputs decode registered state and queue storage only, so no
    // combinational path exists from av_waitrequest.
    assign av_write     = (state == WR);
    assign av_read      = (state == RD);
    assign av_address   = (state == WR) ? wq_dout[QW-1 -: ADDR_W] : rd_addr;
    assign av_writedata = wq_dout[DATA_W-1:0];

    // Holding the stall through RD_CAP lets the MCU's read see fresh rdata.
    assign mcu_wait = wq_full | rd_pend | (state == RD_CAP);
    assign status   = {8'h00, overflow, auto_inc, rd_pend, STAT_CNT_W'(wq_count)};

endmodule
